// File: rtl/tri_des_loader.sv
// ============================================================================
// Module      : tri_des_loader
// Description : Byte-stream loader for a 3DES core. It loads K1/K2/K3 and a
//               64-bit block, then launches the core. Optional key parity
//               check is enabled with macro KEY_PARITY_CHECK_EN.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module tri_des_loader (
    input  logic        clk,
    input  logic        rst,
    input  logic        key_load,
    input  logic        in_valid,
    input  logic [7:0]  in_data,
    output logic        in_ready,
    output logic [0:63] des_in,
    output logic [0:63] key1,
    output logic [0:63] key2,
    output logic [0:63] key3,
    output logic        start,
    input  logic        core_done,
    output logic        busy,
    output logic        keys_valid,
    output logic        key_err
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_KEY   = 3'd1,
        S_DATA  = 3'd2,
        S_START = 3'd3,
        S_WAIT  = 3'd4
    } state_t;

    state_t      state_q, state_d;
    logic [4:0]  cnt_q;
    logic [0:63] des_in_q, key1_q, key2_q, key3_q;
    logic        keys_valid_q;
    logic        w_accept;
    logic        w_err_next;
    logic [5:0]  w_off;

    assign w_accept   = in_valid && in_ready;
    assign w_off      = {cnt_q[2:0], 3'b000};
    assign des_in     = des_in_q;
    assign key1       = key1_q;
    assign key2       = key2_q;
    assign key3       = key3_q;
    assign keys_valid = keys_valid_q;

`ifdef KEY_PARITY_CHECK_EN
    logic err_acc_q;
    logic key_err_q;

    // A key byte with even parity poisons the whole bundle.
    assign w_err_next = err_acc_q | ~(^in_data);
    assign key_err    = key_err_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            err_acc_q <= 1'b0;
            key_err_q <= 1'b0;
        end else if (state_q == S_IDLE && key_load) begin
            err_acc_q <= 1'b0;
            key_err_q <= 1'b0;
        end else if (state_q == S_KEY && w_accept) begin
            err_acc_q <= w_err_next;
            if (cnt_q == 5'd23) begin
                key_err_q <= w_err_next;
            end
        end
    end
`else
    assign w_err_next = 1'b0;
    assign key_err    = 1'b0;
`endif

    always_comb begin
        state_d  = state_q;
        in_ready = 1'b0;
        start    = 1'b0;
        busy     = (state_q != S_IDLE);
        case (state_q)
            S_IDLE: begin
                in_ready = keys_valid_q && !key_load;
                if (key_load) begin
                    state_d = S_KEY;
                end else if (in_valid && in_ready) begin
                    state_d = S_DATA;
                end
            end
            S_KEY: begin
                in_ready = 1'b1;
                if (in_valid && cnt_q == 5'd23) begin
                    state_d = S_IDLE;
                end
            end
            S_DATA: begin
                in_ready = 1'b1;
                if (in_valid && cnt_q == 5'd7) begin
                    state_d = S_START;
                end
            end
            S_START: begin
                start   = 1'b1;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (core_done) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= S_IDLE;
            cnt_q        <= 5'd0;
            des_in_q     <= '0;
            key1_q       <= '0;
            key2_q       <= '0;
            key3_q       <= '0;
            keys_valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            case (state_q)
                S_IDLE: begin
                    if (key_load) begin
                        cnt_q        <= 5'd0;
                        keys_valid_q <= 1'b0;
                    end else if (w_accept) begin
                        des_in_q[0 +: 8] <= in_data;
                        cnt_q            <= 5'd1;
                    end
                end
                S_KEY: begin
                    if (w_accept) begin
                        case (cnt_q[4:3])
                            2'd0:    key1_q[w_off +: 8] <= in_data;
                            2'd1:    key2_q[w_off +: 8] <= in_data;
                            default: key3_q[w_off +: 8] <= in_data;
                        endcase
                        if (cnt_q == 5'd23) begin
                            cnt_q        <= 5'd0;
                            keys_valid_q <= !w_err_next;
                        end else begin
                            cnt_q <= cnt_q + 5'd1;
                        end
                    end
                end
                S_DATA: begin
                    if (w_accept) begin
                        des_in_q[w_off +: 8] <= in_data;
                        cnt_q <= (cnt_q == 5'd7) ? 5'd0 : cnt_q + 5'd1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

`default_nettype wire
